// File: rtl/teclado_pkg.sv
// Shared definitions for the scanned keypad reader.
// Holds the FSM state encoding, the key code width and the default
// matrix geometry / timing constants used as parameter defaults.
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam int KEY_W        = 4;
  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 4;
  localparam int SCAN_DIV_DEF = 4;
  localparam int DEB_CYC_DEF  = 16;

endpackage

// File: rtl/sinc_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
// Ports: clk, rst (async, active-high), din (raw async input),
//        dout (synchronised, 2-cycle latency). Resets to all-ones (idle).
module sinc_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/teclado_varredura.sv
// Scanned-matrix keypad reader: walks a one-cold row drive, reads the
// columns back, debounces press and release, strobes one key code per press.
// Ports: clk, rst (async, active-high), row_n (row drive, one-cold),
//        col_n (raw columns, low = closed), key_valid (1-cycle strobe),
//        key_code (row*COLS+col of last accepted key), key_held (press..release).
module teclado_varredura
  import teclado_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEB_CYC  = DEB_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ROWS-1:0]  row_n,
  input  logic [COLS-1:0]  col_n,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held
);

  localparam int RW = (ROWS > 1)     ? $clog2(ROWS)     : 1;
  localparam int CW = (COLS > 1)     ? $clog2(COLS)     : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEB_CYC > 1)  ? $clog2(DEB_CYC)  : 1;

  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEB_CYC - 1);

  // All column decisions use the synchronised copy.
  logic [COLS-1:0] col_s;

  sinc_2ff #(.W(COLS)) u_sinc (
    .clk  (clk),
    .rst  (rst),
    .din  (col_n),
    .dout (col_s)
  );

  state_t        state, state_nxt;
  logic [RW-1:0] row_idx, row_nxt;
  logic [CW-1:0] col_idx, col_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [BW-1:0] deb_cnt, deb_nxt;
  logic             valid_nxt;
  logic [KEY_W-1:0] code_nxt;
  logic             held_nxt;

  logic          any_low;
  logic [CW-1:0] first_col;
  logic [RW-1:0] row_inc;
  logic          col_open;
  logic [KEY_W-1:0] code_calc;

  // Lowest-index closed column wins when several keys share a row:
  // iterate downwards so the last assignment is the smallest index.
  always_comb begin
    first_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s[c]) first_col = CW'(c);
    end
  end

  assign any_low   = ~&col_s;
  assign row_inc   = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
  assign col_open  = col_s[col_idx];
  assign code_calc = KEY_W'(32'(row_idx) * 32'(COLS) + 32'(col_idx));

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    col_nxt   = col_idx;
    dwell_nxt = dwell;
    deb_nxt   = deb_cnt;
    valid_nxt = 1'b0;
    code_nxt  = key_code;
    held_nxt  = key_held;

    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (any_low) begin
            // Row stays where it is; only the column needs latching.
            col_nxt   = first_col;
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            row_nxt = row_inc;
          end
        end else begin
          dwell_nxt = dwell + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (col_open) begin
          // Bounce: drop the candidate and move on without a strobe.
          state_nxt = SCAN;
          row_nxt   = row_inc;
          dwell_nxt = '0;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          valid_nxt = 1'b1;
          code_nxt  = code_calc;
          held_nxt  = 1'b1;
          state_nxt = HELD;
          deb_nxt   = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end

      HELD: begin
        // Counter here measures consecutive open cycles; any closed
        // cycle restarts the release window.
        if (col_open) begin
          if (deb_cnt == DEB_LAST) begin
            held_nxt  = 1'b0;
            state_nxt = SCAN;
            row_nxt   = row_inc;
            dwell_nxt = '0;
            deb_nxt   = '0;
          end else begin
            deb_nxt = deb_cnt + 1'b1;
          end
        end else begin
          deb_nxt = '0;
        end
      end

      default: begin
        state_nxt = SCAN;
        row_nxt   = '0;
        dwell_nxt = '0;
        deb_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      row_idx   <= '0;
      col_idx   <= '0;
      dwell     <= '0;
      deb_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      row_n     <= {{(ROWS-1){1'b1}}, 1'b0};
    end else begin
      state     <= state_nxt;
      row_idx   <= row_nxt;
      col_idx   <= col_nxt;
      dwell     <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      key_valid <= valid_nxt;
      key_code  <= code_nxt;
      key_held  <= held_nxt;
      // Row drive is registered from the next row index so the pins
      // never see decoder glitches.
      row_n     <= ~(ROWS'(1) << row_nxt);
    end
  end

endmodule

// File: tb/tb_teclado_varredura.sv
module tb_teclado_varredura;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [15:0] pressed;      // bit r*4+c = key (r,c) closed
  int          total = 0;
  int          bad = 0;
  int          strobes = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  teclado_varredura dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // Passive key matrix with pull-ups: a closed key pulls its column low
  // only while its row is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every strobe pops one expected code.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (key_valid) begin
        strobes++;
        if (prev_valid) check("back_to_back_valid", 32'd1, 32'd0);
        if (exp_q.size() == 0) check("unexpected_strobe", exp_q.size(), 32'd1);
        else check("key_code", key_code, exp_q.pop_front());
      end
      prev_valid = key_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int s0 = strobes;
    int n = 0;
    while (strobes == s0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, strobes - s0, 32'd1);
  endtask

  task automatic wait_release(input string tag, input int exp_cycles);
    int n = 0;
    while (key_held && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    int s;
    int n;
    logic [3:0] last;
    logic [3:0] e;

    rst = 1'b1;
    pressed = '0;
    repeat (2) tick();
    check("rst_row_n", row_n, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'd0);
    check("rst_held", key_held, 1'b0);

    // Idle scan: four cycles per row, wrapping.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      e = ~(4'b0001 << ((i / 4) % 4));
      check("idle_row", row_n, e);
      @(negedge clk);
    end
    #1;

    // Clean press of row2/col1.
    pressed[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_strobe("press_r2c1_strobe", 100);
    check("press_r2c1_held", key_held, 1'b1);
    check("press_r2c1_code", key_code, 4'd9);
    repeat (5) tick();
    s = strobes;
    pressed[9] = 1'b0;
    wait_release("release_r2c1_cycles", 18);
    check("resume_row3", row_n, 4'b0111);
    check("no_extra_strobe_r2c1", strobes - s, 32'd0);

    // Bounce on row0/col1: closed 5 cycles starting at row0 dwell 0.
    n = 0;
    last = row_n;
    tick();
    while (!(row_n == 4'b1110 && last != 4'b1110) && n < 50) begin
      last = row_n;
      tick();
      n++;
    end
    check("sync_row0", row_n, 4'b1110);
    s = strobes;
    pressed[1] = 1'b1;
    repeat (5) tick();
    pressed[1] = 1'b0;
    n = 0;
    while (row_n == 4'b1110 && n < 40) begin
      tick();
      n++;
    end
    check("bounce_resume_row1", row_n, 4'b1101);
    check("bounce_no_strobe", strobes - s, 32'd0);
    check("bounce_code_kept", key_code, 4'd9);

    // Two keys in row1: lowest column wins; other-row press ignored.
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    exp_q.push_back(4'd4);
    wait_strobe("simul_strobe", 100);
    s = strobes;
    pressed[14] = 1'b1;
    repeat (40) tick();
    check("rollover_no_strobe", strobes - s, 32'd0);
    check("rollover_held", key_held, 1'b1);
    pressed = '0;
    wait_release("simul_release_cycles", 18);
    check("simul_code_kept", key_code, 4'd4);

    // Release glitch: open 10, closed 1, then open until release.
    pressed[0] = 1'b1;
    exp_q.push_back(4'd0);
    wait_strobe("glitch_strobe", 100);
    repeat (3) tick();
    pressed[0] = 1'b0;
    repeat (10) tick();
    check("glitch_still_held", key_held, 1'b1);
    pressed[0] = 1'b1;
    tick();
    pressed[0] = 1'b0;
    wait_release("glitch_release_cycles", 18);

    // Asynchronous reset in the middle of HELD.
    pressed[11] = 1'b1;
    exp_q.push_back(4'd11);
    wait_strobe("r2c3_strobe", 100);
    repeat (3) tick();
    check("pre_rst_held", key_held, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_row_n", row_n, 4'b1110);
    check("midrst_valid", key_valid, 1'b0);
    check("midrst_code", key_code, 4'd0);
    check("midrst_held", key_held, 1'b0);
    pressed = '0;
    tick();
    rst = 1'b0;
    repeat (50) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    check("strobe_total", strobes, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
